// File: rtl/control_unit_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// The slave side is the controller; the master side drives IR fields and the zero flag.
interface control_unit_if;
   logic [5:0] i_opcode;
   logic [5:0] i_funct;
   logic       i_zero;
   logic       o_reg_write;
   logic       o_pc_write;
   logic       o_mem_read;
   logic       o_mem_write;
   logic       o_ir_write;
   logic       o_reg_a_load;
   logic       o_reg_b_load;
   logic       o_alu_out_load;
   logic       o_alu_src_a;
   logic       o_alu_o_src;
   logic [1:0] o_reg_dst;
   logic [1:0] o_alu_src_b;
   logic [2:0] o_i_or_d;
   logic [2:0] o_pc_src;
   logic [2:0] o_alu_op;
   logic [3:0] o_mem_to_reg;
   logic       o_illegal_op;
   logic [4:0] o_state;

   modport master (
      output i_opcode, i_funct, i_zero,
      input  o_reg_write, o_pc_write, o_mem_read, o_mem_write, o_ir_write,
             o_reg_a_load, o_reg_b_load, o_alu_out_load, o_alu_src_a, o_alu_o_src,
             o_reg_dst, o_alu_src_b, o_i_or_d, o_pc_src, o_alu_op, o_mem_to_reg,
             o_illegal_op, o_state
   );

   modport slave (
      input  i_opcode, i_funct, i_zero,
      output o_reg_write, o_pc_write, o_mem_read, o_mem_write, o_ir_write,
             o_reg_a_load, o_reg_b_load, o_alu_out_load, o_alu_src_a, o_alu_o_src,
             o_reg_dst, o_alu_src_b, o_i_or_d, o_pc_src, o_alu_op, o_mem_to_reg,
             o_illegal_op, o_state
   );
endinterface

// File: rtl/control_unit.sv
// Multicycle MIPS-subset control FSM: one instruction in flight, one state per cycle
// except the memory read waits, which are stretched by a down-counter.
module control_unit #(
   parameter int unsigned MEM_WAIT_CYCLES = 1
) (
   input logic          clk,
   input logic          rst,
   control_unit_if.slave ctl
);
   typedef enum logic [4:0] {
      S_RESET = 5'd0,  S_FETCH0 = 5'd1,  S_FETCH1 = 5'd2,   S_FETCH2 = 5'd3,
      S_DECODE = 5'd4, S_R_EXEC = 5'd5,  S_R_WB = 5'd6,     S_ADDI_EXEC = 5'd7,
      S_ADDI_WB = 5'd8, S_MEM_ADDR = 5'd9, S_LW_READ0 = 5'd10, S_LW_READ1 = 5'd11,
      S_LW_WB = 5'd12, S_SW_WRITE = 5'd13, S_BRANCH = 5'd14, S_JUMP = 5'd15,
      S_JAL = 5'd16,   S_JR = 5'd17
   } state_t;

   localparam logic [1:0] WAIT_INIT = 2'(MEM_WAIT_CYCLES);

   state_t     r_state, w_next;
   logic [1:0] r_wait;

   logic       w_reg_write, w_pc_write, w_mem_read, w_mem_write, w_ir_write;
   logic       w_reg_a_load, w_reg_b_load, w_alu_out_load, w_alu_src_a, w_illegal_op;
   logic [1:0] w_reg_dst, w_alu_src_b;
   logic [2:0] w_i_or_d, w_pc_src, w_alu_op;
   logic [3:0] w_mem_to_reg;
   logic       w_is_rtype, w_r_alu, w_r_jr;

   assign w_is_rtype = (ctl.i_opcode == 6'h00);
   assign w_r_alu    = w_is_rtype && (ctl.i_funct == 6'h20 || ctl.i_funct == 6'h22 ||
                                      ctl.i_funct == 6'h24 || ctl.i_funct == 6'h2A);
   assign w_r_jr     = w_is_rtype && (ctl.i_funct == 6'h08);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_RESET;
         r_wait  <= 2'd0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_FETCH0, S_LW_READ0: r_wait <= WAIT_INIT;
            S_FETCH1, S_LW_READ1: r_wait <= r_wait - 2'd1;
            default:              r_wait <= r_wait;
         endcase
      end
   end

   always_comb begin
      w_next         = S_FETCH0;
      w_reg_write    = 1'b0;
      w_pc_write     = 1'b0;
      w_mem_read     = 1'b0;
      w_mem_write    = 1'b0;
      w_ir_write     = 1'b0;
      w_reg_a_load   = 1'b0;
      w_reg_b_load   = 1'b0;
      w_alu_out_load = 1'b0;
      w_alu_src_a    = 1'b0;
      w_illegal_op   = 1'b0;
      w_reg_dst      = 2'b00;
      w_alu_src_b    = 2'b00;
      w_i_or_d       = 3'b000;
      w_pc_src       = 3'b000;
      w_alu_op       = 3'b000;
      w_mem_to_reg   = 4'b0000;
      case (r_state)
         S_RESET: w_next = S_FETCH0;
         S_FETCH0: begin
            w_mem_read = 1'b1;
            w_next     = (WAIT_INIT == 2'd0) ? S_FETCH2 : S_FETCH1;
         end
         S_FETCH1: begin
            w_mem_read = 1'b1;
            w_next     = (r_wait <= 2'd1) ? S_FETCH2 : S_FETCH1;
         end
         S_FETCH2: begin
            w_ir_write  = 1'b1;
            w_pc_write  = 1'b1;
            w_alu_src_b = 2'b01;
            w_alu_op    = 3'b001;
            w_next      = S_DECODE;
         end
         S_DECODE: begin
            w_reg_a_load   = 1'b1;
            w_reg_b_load   = 1'b1;
            w_alu_src_b    = 2'b11;
            w_alu_op       = 3'b001;
            w_alu_out_load = 1'b1;
            case (ctl.i_opcode)
               6'h00: begin
                  if (w_r_alu)     w_next = S_R_EXEC;
                  else if (w_r_jr) w_next = S_JR;
                  else begin
                     w_illegal_op = 1'b1;
                     w_next       = S_FETCH0;
                  end
               end
               6'h08:        w_next = S_ADDI_EXEC;
               6'h23, 6'h2B: w_next = S_MEM_ADDR;
               6'h04, 6'h05: w_next = S_BRANCH;
               6'h02:        w_next = S_JUMP;
               6'h03:        w_next = S_JAL;
               default: begin
                  w_illegal_op = 1'b1;
                  w_next       = S_FETCH0;
               end
            endcase
         end
         S_R_EXEC: begin
            w_alu_src_a    = 1'b1;
            w_alu_out_load = 1'b1;
            case (ctl.i_funct)
               6'h22:   w_alu_op = 3'b010;
               6'h24:   w_alu_op = 3'b011;
               6'h2A:   w_alu_op = 3'b111;
               default: w_alu_op = 3'b001;
            endcase
            w_next = S_R_WB;
         end
         S_R_WB: begin
            w_reg_write  = 1'b1;
            w_reg_dst    = 2'b01;
            w_mem_to_reg = (ctl.i_funct == 6'h2A) ? 4'b0010 : 4'b0000;
         end
         S_ADDI_EXEC: begin
            w_alu_src_a    = 1'b1;
            w_alu_src_b    = 2'b10;
            w_alu_op       = 3'b001;
            w_alu_out_load = 1'b1;
            w_next         = S_ADDI_WB;
         end
         S_ADDI_WB: w_reg_write = 1'b1;
         S_MEM_ADDR: begin
            w_alu_src_a    = 1'b1;
            w_alu_src_b    = 2'b10;
            w_alu_op       = 3'b001;
            w_alu_out_load = 1'b1;
            w_next         = (ctl.i_opcode == 6'h23) ? S_LW_READ0 : S_SW_WRITE;
         end
         S_LW_READ0: begin
            w_mem_read = 1'b1;
            w_i_or_d   = 3'b001;
            w_next     = (WAIT_INIT == 2'd0) ? S_LW_WB : S_LW_READ1;
         end
         S_LW_READ1: begin
            w_mem_read = 1'b1;
            w_i_or_d   = 3'b001;
            w_next     = (r_wait <= 2'd1) ? S_LW_WB : S_LW_READ1;
         end
         S_LW_WB: begin
            w_reg_write  = 1'b1;
            w_mem_to_reg = 4'b0001;
         end
         S_SW_WRITE: begin
            w_mem_write = 1'b1;
            w_i_or_d    = 3'b001;
         end
         // Mealy: the branch decision follows the live zero flag.
         S_BRANCH: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = 3'b010;
            w_pc_src    = 3'b001;
            w_pc_write  = ((ctl.i_opcode == 6'h04) &&  ctl.i_zero) ||
                          ((ctl.i_opcode == 6'h05) && !ctl.i_zero);
         end
         S_JUMP: begin
            w_pc_write = 1'b1;
            w_pc_src   = 3'b010;
         end
         S_JAL: begin
            w_pc_write   = 1'b1;
            w_pc_src     = 3'b010;
            w_reg_write  = 1'b1;
            w_reg_dst    = 2'b10;
            w_mem_to_reg = 4'b0011;
         end
         S_JR: begin
            w_alu_src_a = 1'b1;
            w_pc_write  = 1'b1;
         end
         default: w_next = S_FETCH0;
      endcase
   end

   assign ctl.o_reg_write    = w_reg_write;
   assign ctl.o_pc_write     = w_pc_write;
   assign ctl.o_mem_read     = w_mem_read;
   assign ctl.o_mem_write    = w_mem_write;
   assign ctl.o_ir_write     = w_ir_write;
   assign ctl.o_reg_a_load   = w_reg_a_load;
   assign ctl.o_reg_b_load   = w_reg_b_load;
   assign ctl.o_alu_out_load = w_alu_out_load;
   assign ctl.o_alu_src_a    = w_alu_src_a;
   assign ctl.o_alu_o_src    = 1'b0;
   assign ctl.o_reg_dst      = w_reg_dst;
   assign ctl.o_alu_src_b    = w_alu_src_b;
   assign ctl.o_i_or_d       = w_i_or_d;
   assign ctl.o_pc_src       = w_pc_src;
   assign ctl.o_alu_op       = w_alu_op;
   assign ctl.o_mem_to_reg   = w_mem_to_reg;
   assign ctl.o_illegal_op   = w_illegal_op;
   assign ctl.o_state        = r_state;
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: one instance at one wait cycle, one at three.
module tb_control_unit;
   localparam logic [4:0] ST_RESET = 5'd0,  ST_F0 = 5'd1,  ST_F1 = 5'd2,  ST_F2 = 5'd3;
   localparam logic [4:0] ST_DEC = 5'd4,   ST_REX = 5'd5, ST_RWB = 5'd6;
   localparam logic [4:0] ST_LR0 = 5'd10,  ST_LR1 = 5'd11, ST_LWB = 5'd12;
   localparam logic [4:0] ST_BR = 5'd14,   ST_JAL = 5'd16, ST_JR = 5'd17;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   control_unit_if ifa ();
   control_unit_if ifb ();

   control_unit #(.MEM_WAIT_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .ctl(ifa));
   control_unit #(.MEM_WAIT_CYCLES(3)) dut_b (.clk(clk), .rst(rst), .ctl(ifb));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [27:0] outs_a();
      return {ifa.o_reg_write, ifa.o_pc_write, ifa.o_mem_read, ifa.o_mem_write,
              ifa.o_ir_write, ifa.o_reg_a_load, ifa.o_reg_b_load, ifa.o_alu_out_load,
              ifa.o_alu_src_a, ifa.o_alu_o_src, ifa.o_reg_dst, ifa.o_alu_src_b,
              ifa.o_i_or_d, ifa.o_pc_src, ifa.o_alu_op, ifa.o_mem_to_reg, ifa.o_illegal_op};
   endfunction

   function automatic logic [3:0] writes_a();
      return {ifa.o_reg_write, ifa.o_pc_write, ifa.o_mem_write, ifa.o_ir_write};
   endfunction

   task automatic set_a(input logic [5:0] op, input logic [5:0] fn, input logic z);
      ifa.i_opcode = op;
      ifa.i_funct  = fn;
      ifa.i_zero   = z;
   endtask

   // Runs one lw on the chosen instance from FETCH0 back to FETCH0.
   task automatic lw_run(input bit use_b, input string tag, input int exp_cyc);
      int   cyc = 0;
      logic rd_ok = 1'b1;
      logic [4:0] st;
      logic [3:0] m2r = 4'hF;
      logic [1:0] dst = 2'b11;
      do begin
         st = use_b ? ifb.o_state : ifa.o_state;
         if (st == ST_LR0 || st == ST_LR1) begin
            if (use_b) rd_ok &= ifb.o_mem_read && (ifb.o_i_or_d == 3'b001) && !ifb.o_mem_write;
            else       rd_ok &= ifa.o_mem_read && (ifa.o_i_or_d == 3'b001) && !ifa.o_mem_write;
         end
         if (st == ST_LWB) begin
            m2r = use_b ? ifb.o_mem_to_reg : ifa.o_mem_to_reg;
            dst = use_b ? ifb.o_reg_dst : ifa.o_reg_dst;
         end
         tick();
         cyc++;
         st = use_b ? ifb.o_state : ifa.o_state;
      end while (st != ST_F0 && cyc < 40);
      check({tag, "_cycles"}, cyc, exp_cyc);
      check({tag, "_read_hold"}, rd_ok, 1);
      check({tag, "_wb_memtoreg"}, m2r, 4'b0001);
      check({tag, "_wb_regdst"}, dst, 2'b00);
   endtask

   initial begin
      int guard;
      set_a(6'h00, 6'h20, 1'b0);
      ifb.i_opcode = 6'h23;
      ifb.i_funct  = 6'h00;
      ifb.i_zero   = 1'b0;

      tick(2);
      check("reset_state", ifa.o_state, ST_RESET);
      check("reset_outs", outs_a(), 0);
      rst = 1'b0;
      tick();
      check("f0_state", ifa.o_state, ST_F0);
      check("f0_memread_iord", {ifa.o_mem_read, ifa.o_i_or_d}, 4'b1000);

      // add
      tick();  check("add_f1", ifa.o_state, ST_F1);
      tick();  check("add_f2", ifa.o_state, ST_F2);
      check("add_f2_strobes", {ifa.o_ir_write, ifa.o_pc_write, ifa.o_pc_src, ifa.o_alu_src_b, ifa.o_alu_op},
            {1'b1, 1'b1, 3'b000, 2'b01, 3'b001});
      tick();  check("add_dec", ifa.o_state, ST_DEC);
      check("add_dec_alu", {ifa.o_alu_src_b, ifa.o_alu_op, ifa.o_alu_out_load}, {2'b11, 3'b001, 1'b1});
      tick();  check("add_rex", ifa.o_state, ST_REX);
      check("add_rex_alu", {ifa.o_alu_op, ifa.o_alu_src_b, ifa.o_alu_src_a}, {3'b001, 2'b00, 1'b1});
      tick();  check("add_rwb", ifa.o_state, ST_RWB);
      check("add_rwb_ctl", {ifa.o_reg_write, ifa.o_reg_dst, ifa.o_mem_to_reg}, {1'b1, 2'b01, 4'b0000});
      tick();  check("add_back_f0", ifa.o_state, ST_F0);

      set_a(6'h23, 6'h00, 1'b0);
      lw_run(1'b0, "lw_w1", 8);

      // beq / bne: PCWrite follows zero within the BRANCH cycle
      set_a(6'h04, 6'h00, 1'b1);
      tick(4); check("beq_state", ifa.o_state, ST_BR);
      #1;      check("beq_z1", {ifa.o_pc_write, ifa.o_pc_src}, {1'b1, 3'b001});
      ifa.i_zero = 1'b0;
      #1;      check("beq_z0", ifa.o_pc_write, 1'b0);
      tick();  check("beq_back_f0", ifa.o_state, ST_F0);
      set_a(6'h05, 6'h00, 1'b0);
      tick(4); check("bne_z0", {ifa.o_state, ifa.o_pc_write}, {ST_BR, 1'b1});
      ifa.i_zero = 1'b1;
      #1;      check("bne_z1", ifa.o_pc_write, 1'b0);
      tick();

      set_a(6'h03, 6'h00, 1'b0);
      tick(4); check("jal_state", ifa.o_state, ST_JAL);
      check("jal_ctl", {ifa.o_pc_write, ifa.o_pc_src, ifa.o_reg_write, ifa.o_reg_dst, ifa.o_mem_to_reg},
            {1'b1, 3'b010, 1'b1, 2'b10, 4'b0011});
      tick();  check("jal_back_f0", ifa.o_state, ST_F0);

      set_a(6'h00, 6'h2A, 1'b0);
      tick(4); check("slt_rex_aluop", ifa.o_alu_op, 3'b111);
      tick();  check("slt_rwb", {ifa.o_state, ifa.o_mem_to_reg, ifa.o_reg_dst}, {ST_RWB, 4'b0010, 2'b01});
      tick();

      set_a(6'h00, 6'h08, 1'b0);
      tick(4); check("jr_ctl", {ifa.o_state, ifa.o_pc_write, ifa.o_alu_op, ifa.o_alu_src_a, ifa.o_pc_src},
                     {ST_JR, 1'b1, 3'b000, 1'b1, 3'b000});
      tick();

      set_a(6'h3F, 6'h00, 1'b0);
      tick(3); check("ill_op_dec", {ifa.o_state, ifa.o_illegal_op, writes_a()}, {ST_DEC, 1'b1, 4'b0000});
      tick();  check("ill_op_next", {ifa.o_state, ifa.o_illegal_op}, {ST_F0, 1'b0});
      set_a(6'h00, 6'h01, 1'b0);
      tick(3); check("ill_fn_dec", {ifa.o_state, ifa.o_illegal_op, writes_a()}, {ST_DEC, 1'b1, 4'b0000});
      tick();  check("ill_fn_next", {ifa.o_state, ifa.o_illegal_op}, {ST_F0, 1'b0});

      // asynchronous reset in the middle of a load
      set_a(6'h23, 6'h00, 1'b0);
      tick(6); check("mid_lr1", ifa.o_state, ST_LR1);
      #2 rst = 1'b1;
      #1;      check("async_rst_state", ifa.o_state, ST_RESET);
      check("async_rst_outs", outs_a(), 0);
      tick();  rst = 1'b0;
      #1;      check("rst_hold", ifa.o_state, ST_RESET);
      tick();  check("rst_rel_f0", {ifa.o_state, ifa.o_mem_read, ifa.o_i_or_d}, {ST_F0, 1'b1, 3'b000});

      // three wait cycles: align to a fresh FETCH0 on instance b
      guard = 0;
      while (ifb.o_state != ST_F0 && guard < 40) begin
         tick();
         guard++;
      end
      check("b_reach_f0", ifb.o_state, ST_F0);
      lw_run(1'b1, "lw_w3", 12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
